// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset PC, FSM encodings, FIFO entry layout.
// No logic; imported by every fetch-unit file.
package instruction_fetch_unit_pkg;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int IFU_FIFO_DEPTH = 2;
    localparam logic [ADDR_W-1:0] IFU_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect/halt control,
// and the decode-side valid/ready head. master = fetch unit, slave = memory/decode side.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic [ADDR_W-1:0] A_InstrAddress;
    logic              C_IMRead;
    logic [DATA_W-1:0] D_Instruction;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halt;
    logic [DATA_W-1:0] F_Instr;
    logic [ADDR_W-1:0] F_PC;
    logic              F_Valid;
    logic              F_Ready;

    modport master (
        output A_InstrAddress, C_IMRead, F_Instr, F_PC, F_Valid,
        input  D_Instruction, redirect_valid, redirect_addr, halt, F_Ready
    );

    modport slave (
        input  A_InstrAddress, C_IMRead, F_Instr, F_PC, F_Valid,
        output D_Instruction, redirect_valid, redirect_addr, halt, F_Ready
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} with synchronous flush; head is read from storage.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: caller never pushes when full; push+pop in one cycle keeps count.
module instruction_fetch_unit_fetch_fifo
    import instruction_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = IFU_FIFO_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_dat,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [CW-1:0] o_count,
    output logic         o_head_vld,
    output fetch_entry_t o_head_dat
);
    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_head_vld = (r_count != '0);
    assign o_head_dat = r_mem[r_rd_ptr];

    // Issue throttling reserves a slot for every in-flight read, so a push never meets a full FIFO.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && r_count == CW'(DEPTH)));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns PC, issues one word read per cycle, queues {pc, instr} for decode.
// Latency: read issued in t -> F_Valid in t+2; redirect in t -> F_Valid at target in t+3.
// Backpressure: reads stop when FIFO entries plus the in-flight read would exceed depth.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                FIFO_DEPTH = IFU_FIFO_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC   = IFU_RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    instruction_fetch_unit_if.master  bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic              r_inflight;
    logic              r_drop;

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_redirect;
    logic [CW:0]       w_occupancy;
    logic [CW-1:0]     w_count;
    logic              w_head_vld;
    fetch_entry_t      w_head_dat;
    fetch_entry_t      w_push_dat;

    assign w_redirect = bus.redirect_valid;
    assign w_pop      = w_head_vld & bus.F_Ready;
    assign w_push     = r_inflight & ~r_drop & ~w_redirect;
    assign w_push_dat = '{pc: r_req_pc, instr: bus.D_Instruction};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_BOOT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   if (bus.halt && !w_redirect) w_state_nxt = S_HALT;
            S_HALT:  if (!bus.halt || w_redirect) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // Occupancy counts the read still in flight, less the entry leaving this cycle.
    always_comb begin
        w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
        w_issue     = (r_state == S_RUN) && !bus.halt && !w_redirect &&
                      (w_occupancy < (CW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_drop     <= 1'b0;
        end else if (w_redirect) begin
            r_pc       <= bus.redirect_addr;
            r_inflight <= 1'b0;
            r_drop     <= 1'b1;
        end else begin
            r_inflight <= w_issue;
            r_drop     <= 1'b0;
            if (w_issue) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 1'b1;
            end
        end
    end

    instruction_fetch_unit_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .i_flush    (w_redirect),
        .o_count    (w_count),
        .o_head_vld (w_head_vld),
        .o_head_dat (w_head_dat)
    );

    assign bus.A_InstrAddress = r_pc;
    assign bus.C_IMRead       = w_issue;
    assign bus.F_Instr        = w_head_dat.instr;
    assign bus.F_PC           = w_head_dat.pc;
    assign bus.F_Valid        = w_head_vld;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench: memory model plus scoreboard of the sequential PC stream decode must see;
// directed timing checks followed by a randomized ready/halt/redirect phase.
module tb_instruction_fetch_unit;
    logic clk;
    logic rst;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_xfer   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] tail;
    logic        rd_pend  = 1'b0;
    logic [15:0] rd_addr  = 16'h0;
    logic [15:0] e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference stream: after reset or redirect, decode sees addr, addr+1, ... (16-bit wrap).
    function automatic void restart(input logic [15:0] a);
        exp_q.delete();
        tail = a;
    endfunction

    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back(tail);
            tail = tail + 16'd1;
        end
    endfunction

    // Memory: a read sampled in cycle t returns its word during cycle t+1, garbage otherwise.
    always @(negedge clk) begin
        rd_pend = bus.C_IMRead;
        rd_addr = bus.A_InstrAddress;
    end

    always @(posedge clk) begin
        #1;
        bus.D_Instruction = rd_pend ? mem_word(rd_addr) : 16'($urandom);
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus.halt) check("halt_no_read", 32'(bus.C_IMRead), 32'd0);
            if (!bus.redirect_valid && bus.F_Valid && bus.F_Ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL xfer_extra: got pc %0h, expected no transfer", bus.F_PC);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer", {bus.F_PC, bus.F_Instr}, {e, mem_word(e)});
                    n_xfer++;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        restart(16'h0000);
        refill();
        #1;
        check("rst_read",  32'(bus.C_IMRead),       32'd0);
        check("rst_valid", 32'(bus.F_Valid),        32'd0);
        check("rst_addr",  32'(bus.A_InstrAddress), 32'h0000);
        check("rst_fpc",   32'(bus.F_PC),           32'h0000);
        check("rst_finstr",32'(bus.F_Instr),        32'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int          n_rd;
        int          base;
        logic        found;
        logic [15:0] pc_h;
        logic [15:0] ep;

        rst                = 1'b1;
        bus.F_Ready        = 1'b0;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 16'h0;

        // Full-rate fetch from reset.
        do_reset();
        bus.F_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t1_read",  32'(bus.C_IMRead), (i >= 1) ? 32'd1 : 32'd0);
            check("t1_addr",  32'(bus.A_InstrAddress), (i == 0) ? 32'd0 : 32'(i - 1));
            check("t1_valid", 32'(bus.F_Valid),  (i >= 3) ? 32'd1 : 32'd0);
            cyc();
        end

        // Asynchronous reset mid-stream, then decode stalled from the start.
        bus.F_Ready = 1'b0;
        do_reset();
        n_rd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) check("boot_idle", 32'(bus.C_IMRead), 32'd0);
            if (i == 1) check("restart_addr", {31'd0, bus.C_IMRead} + 32'(bus.A_InstrAddress), 32'd1);
            n_rd += int'(bus.C_IMRead);
            cyc();
        end
        @(negedge clk);
        check("bp_reads", 32'(n_rd), 32'd2);
        check("bp_valid", 32'(bus.F_Valid), 32'd1);
        check("bp_count", 32'(dut.w_count), 32'd2);
        cyc();
        base = n_xfer;
        bus.F_Ready = 1'b1;
        cyc();
        cyc();
        cyc();
        bus.F_Ready = 1'b0;
        @(negedge clk);
        check("bp_release_xfers", 32'(n_xfer - base), 32'd3);
        cyc();
        bus.F_Ready = 1'b1;

        // Redirect while the read of 0x0005 is in flight.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.C_IMRead && bus.A_InstrAddress == 16'h0005) found = 1'b1;
            cyc();
        end
        check("find_read5", 32'(found), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'h0100;
        bus.F_Ready        = 1'b0;
        restart(16'h0100);
        refill();
        @(negedge clk);
        check("redir_no_read", 32'(bus.C_IMRead), 32'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        bus.F_Ready        = 1'b1;
        @(negedge clk);
        check("redir_v1",   32'(bus.F_Valid), 32'd0);
        check("redir_read", 32'(bus.C_IMRead), 32'd1);
        check("redir_addr", 32'(bus.A_InstrAddress), 32'h0100);
        cyc();
        @(negedge clk);
        check("redir_v2", 32'(bus.F_Valid), 32'd0);
        cyc();
        @(negedge clk);
        check("redir_v3",  32'(bus.F_Valid), 32'd1);
        check("redir_fpc", 32'(bus.F_PC), 32'h0100);

        // Redirect near the top of the address space: PC wraps.
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 16'hFFFE;
        restart(16'hFFFE);
        refill();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                ep = 16'hFFFE + 16'(i - 3);
                check("wrap_valid", 32'(bus.F_Valid), 32'd1);
                check("wrap_fpc",   32'(bus.F_PC), 32'(ep));
            end
            cyc();
            bus.redirect_valid = 1'b0;
        end

        // Halt for five cycles mid-stream.
        cyc();
        pc_h = bus.A_InstrAddress;
        bus.halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_pc", 32'(bus.A_InstrAddress), 32'(pc_h));
            cyc();
        end
        bus.halt = 1'b0;
        @(negedge clk);
        cyc();
        @(negedge clk);
        check("resume_read", 32'(bus.C_IMRead), 32'd1);
        check("resume_pc",   32'(bus.A_InstrAddress), 32'(pc_h));

        // Randomized ready / halt / redirect traffic.
        base = n_xfer;
        for (int i = 0; i < 600; i++) begin
            cyc();
            bus.F_Ready = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) bus.halt = ~bus.halt;
            if ($urandom_range(31) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_addr  = 16'($urandom);
                restart(bus.redirect_addr);
                refill();
            end else begin
                bus.redirect_valid = 1'b0;
            end
        end
        cyc();
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.F_Ready        = 1'b1;
        repeat (10) cyc();
        @(negedge clk);
        check("rand_xfers", 32'(n_xfer > base + 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
